// File: rtl/csb_pkg.sv
// csb_pkg: shared FSM states, timeout read data and payload field offsets for csb_master_bridge
package csb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} csb_state_e;
  localparam logic [31:0] CSB_TIMEOUT_DATA = 32'hDEAD_BEEF;
  function automatic int pd_wr_bit(input int l);
    return l + 33;
  endfunction
  function automatic int pd_data_lsb(input int l);
    return l + 1;
  endfunction
  function automatic int pd_width(input int l);
    return l + 34;
  endfunction
endpackage

// File: rtl/csb_timeout_cnt.sv
// csb_timeout_cnt: read-response wait counter, expires when the count reaches LIMIT
module csb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1) > 8 ? $clog2(LIMIT + 1) : 8;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clear) ? '0 : enable ? cnt + 1'b1 : cnt;
  assign expire = cnt == W'(LIMIT);
endmodule

// File: rtl/csb_master_bridge.sv
// csb_master_bridge: serialises host register accesses into single-outstanding CSB requests.
// Define CSB_TIMEOUT_EN to bound the read-response wait and flag expired reads with host_resp_err.
module csb_master_bridge
  import csb_pkg::*;
#(
  parameter int LOG2_CSR_REG_NUM = 5,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             host_req_vld,
  output logic                             host_req_rdy,
  input  logic                             host_req_wr,
  input  logic [LOG2_CSR_REG_NUM:0]        host_req_addr,
  input  logic [31:0]                      host_req_wdata,
  output logic                             host_resp_vld,
  input  logic                             host_resp_rdy,
  output logic                             host_resp_wr,
  output logic [31:0]                      host_resp_rdata,
  output logic                             host_resp_err,
  output logic                             csb2csr_req_vld,
  input  logic                             csb2csr_req_rdy,
  output logic [LOG2_CSR_REG_NUM+33:0]     csb2csr_req_pd,
  input  logic                             csr2csb_resp_vld,
  input  logic [31:0]                      csr2csb_resp_pd
);
  localparam int WB  = pd_wr_bit(LOG2_CSR_REG_NUM);
  localparam int DL  = pd_data_lsb(LOG2_CSR_REG_NUM);
  localparam int PDW = pd_width(LOG2_CSR_REG_NUM);
  csb_state_e state;
  logic timeout;
  logic [PDW-1:0] pd_next;
  assign pd_next = {host_req_wr, host_req_wr ? host_req_wdata : 32'h0, host_req_addr};
`ifdef CSB_TIMEOUT_EN
  csb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
    .clk(clk),
    .rst(rst),
    .clear(state != WAIT_RD),
    .enable(state == WAIT_RD),
    .expire(timeout)
  );
  // a response landing on the limit cycle wins over the timeout
  always_ff @(posedge clk)
    if (rst) host_resp_err <= 1'b0;
    else if (state == ISSUE && csb2csr_req_rdy && csb2csr_req_pd[WB]) host_resp_err <= 1'b0;
    else if (state == WAIT_RD && (csr2csb_resp_vld || timeout)) host_resp_err <= !csr2csb_resp_vld;
`else
  assign timeout = 1'b0;
  assign host_resp_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      host_req_rdy    <= 1'b0;
      csb2csr_req_vld <= 1'b0;
      csb2csr_req_pd  <= '0;
      host_resp_vld   <= 1'b0;
      host_resp_wr    <= 1'b0;
      host_resp_rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (host_req_vld && host_req_rdy) begin
            state           <= ISSUE;
            host_req_rdy    <= 1'b0;
            csb2csr_req_vld <= 1'b1;
            csb2csr_req_pd  <= pd_next;
          end else begin
            host_req_rdy <= 1'b1;
          end
        ISSUE:
          if (csb2csr_req_rdy) begin
            csb2csr_req_vld <= 1'b0;
            host_resp_wr    <= csb2csr_req_pd[WB];
            if (csb2csr_req_pd[WB]) begin
              state           <= RESP;
              host_resp_vld   <= 1'b1;
              host_resp_rdata <= '0;
            end else begin
              state <= WAIT_RD;
            end
          end
        WAIT_RD:
          if (csr2csb_resp_vld || timeout) begin
            state           <= RESP;
            host_resp_vld   <= 1'b1;
            host_resp_rdata <= csr2csb_resp_vld ? csr2csb_resp_pd : CSB_TIMEOUT_DATA;
          end
        RESP:
          if (host_resp_rdy) begin
            state         <= IDLE;
            host_resp_vld <= 1'b0;
            host_req_rdy  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
  logic unused_pd_lsb;
  assign unused_pd_lsb = ^csb2csr_req_pd[DL-1:0];
endmodule

// File: doc/csb_master_bridge.md
# csb_master_bridge

Serialises host register accesses into single-outstanding CSB requests for the Matrix CSR block. It packs `{wr_rd, wdata, addr}` into the CSB request payload and drives the request with a valid/ready handshake. Read data comes back on the CSR's registered response and is returned to the host with an error flag. The block sits directly upstream of the Matrix CSR port: between the host/AXI-Lite shim and `csb2csr_*` / `csr2csb_*`.

## Interface
Parameters:
- `LOG2_CSR_REG_NUM`, default 5: CSR address is `LOG2_CSR_REG_NUM+1` bits; payload is `LOG2_CSR_REG_NUM+34` bits.
- `TIMEOUT_CYCLES`, default 255: read-response wait limit (only with `CSB_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `host_req_vld` in 1: host request valid.
- `host_req_rdy` out 1: block can accept a request.
- `host_req_wr` in 1: 1 = write, 0 = read.
- `host_req_addr` in `LOG2_CSR_REG_NUM+1`: CSR register index.
- `host_req_wdata` in 32: write data.
- `host_resp_vld` out 1: response valid, held until accepted.
- `host_resp_rdy` in 1: host accepts response.
- `host_resp_wr` out 1: echo of request type.
- `host_resp_rdata` out 32: read data; 0 for writes.
- `host_resp_err` out 1: read timed out.
- `csb2csr_req_vld` out 1: CSB request valid.
- `csb2csr_req_rdy` in 1: CSR accepts.
- `csb2csr_req_pd` out `LOG2_CSR_REG_NUM+34`: payload.
  - bit `[L+33]` = wr_rd.
  - bits `[L+32:L+1]` = wdata.
  - bits `[L:0]` = addr, where L = `LOG2_CSR_REG_NUM`.
- `csr2csb_resp_vld` in 1: read response valid (single-cycle pulse).
- `csr2csb_resp_pd` in 32: read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP. Reset enters IDLE.
- IDLE:
  - `host_req_rdy`=1.
  - On `host_req_vld`, latch wr/addr/wdata into the payload register and go to ISSUE.
- ISSUE:
  - `csb2csr_req_vld`=1 with a stable payload.
  - On `csb2csr_req_rdy`: a write goes to RESP (rdata=0, err=0); a read goes to WAIT_RD.
- WAIT_RD:
  - On `csr2csb_resp_vld`, capture `csr2csb_resp_pd` into rdata, set err=0, go to RESP.
  - A response pulse in the same cycle the state is entered is not possible, because the CSR response is registered.
- RESP:
  - `host_resp_vld`=1; all response fields are held stable.
  - On `host_resp_rdy`, go to IDLE.
- Only one transaction is in flight at a time; `host_req_rdy`=0 outside IDLE.
- `csr2csb_resp_vld` outside WAIT_RD is ignored and does not corrupt held rdata.
- Payload for a write carries wr_rd=1. Payload for a read carries wr_rd=0 and wdata=0.
- Writes to CSR address 0 (start pulses) are not treated specially; they are forwarded unchanged.

## Timing
- Reset values:
  - `host_req_rdy`=0 during reset, 1 the cycle after.
  - `host_resp_vld`=0, `host_resp_wr`=0, `host_resp_rdata`=0, `host_resp_err`=0.
  - `csb2csr_req_vld`=0, `csb2csr_req_pd`=0.
- All outputs are registered or decoded from the state register; there is no host-to-CSB combinational path.
- Latency with `csb2csr_req_rdy` tied 1, taking host accept as cycle 0:
  - `csb2csr_req_vld` is high in cycle 1.
  - Write: `host_resp_vld` in cycle 2.
  - Read: CSR response in cycle 2, `host_resp_vld` in cycle 3.
- Back-to-back: the next request is accepted the cycle after `host_resp_vld & host_resp_rdy`. Minimum write period is 3 cycles.
- `rst` asserted in any state forces IDLE next cycle and drops every valid. A pending CSR response after reset is ignored.

## Configuration
- `CSB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to WAIT_RD and increments each WAIT_RD cycle.
  - At count == `TIMEOUT_CYCLES` with no response: go to RESP with rdata=32'hDEAD_BEEF, err=1.
  - A response arriving in the same cycle as the limit wins: normal data, err=0.
- Undefined:
  - WAIT_RD waits indefinitely.
  - `host_resp_err` is tied 0 and no counter is built.

## Structure
- Shared package `csb_pkg` holds:
  - the state enum;
  - `CSB_TIMEOUT_DATA` = 32'hDEAD_BEEF;
  - the payload field-offset constants derived from `LOG2_CSR_REG_NUM`.
- Optional sub-module `csb_timeout_cnt`, instantiated only under `CSB_TIMEOUT_EN`:
  - inputs: clear, enable;
  - output: expire.
- FSM and payload register stay in the top module.

## Test plan
- Write addr 3, data 32'h1234_5678, CSR rdy=1:
  - cycle 1: pd = {1'b1, 32'h1234_5678, 6'd3};
  - cycle 2: host_resp_vld=1, wr=1, rdata=0.
- Read addr 27, CSR returns 32'h0000_00AA in cycle 2 → cycle 3: host_resp_vld=1, rdata=32'hAA, err=0.
- CSR rdy held 0 for 4 cycles → pd is stable and vld stays 1 throughout; the response follows 1 cycle after rdy.
- `host_resp_rdy`=0 for 5 cycles → response held stable; `host_req_rdy` stays 0; a stray `csr2csb_resp_vld` does not change rdata.
- With `CSB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no CSR response → RESP with rdata=32'hDEAD_BEEF, err=1.
  - Repeat with the response pulse on the limit cycle → real data, err=0.
- `rst` pulsed during WAIT_RD → next cycle IDLE with all valids 0; a late CSR response is ignored; the next read completes normally.
